// File: rtl/fp16_accum_seq_if.sv
// rtl/fp16_accum_seq_if.sv - stream bundle between the fp16 accumulator, its source, the adder and its sink
interface fp16_accum_seq_if #(
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [15:0]      s_data;
  logic             s_last;
  logic             add_valid;
  logic             add_ready;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_sum;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      m_data;
  logic [CNT_W-1:0] m_count;

  modport slave (
    input  s_valid, s_data, s_last, add_ready, res_valid, res_sum, m_ready,
    output s_ready, add_valid, add_a, add_b, res_ready, m_valid, m_data, m_count
  );

  modport master (
    output s_valid, s_data, s_last, add_ready, res_valid, res_sum, m_ready,
    input  s_ready, add_valid, add_a, add_b, res_ready, m_valid, m_data, m_count
  );
endinterface

// File: rtl/fp16_accum_seq.sv
// rtl/fp16_accum_seq.sv - serial fp16 vector accumulator driving an external pipelined fp16 adder
module fp16_accum_seq #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  fp16_accum_seq_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state;
  logic [15:0]      acc;
  logic [15:0]      opnd;
  logic             last_q;
  logic [CNT_W-1:0] cnt;

  // The first element seeds acc directly; every later element costs one adder round trip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      opnd   <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            acc   <= bus.s_data;
            cnt   <= CNT_ONE;
            state <= bus.s_last ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            opnd   <= bus.s_data;
            last_q <= bus.s_last;
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.add_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.res_valid) begin
            acc   <= bus.res_sum;
            state <= last_q ? DONE : LOAD;
          end
        end
        DONE: begin
          if (bus.m_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only, so no input reaches an output combinationally.
  assign bus.s_ready   = (state == IDLE) || (state == LOAD);
  assign bus.add_valid = (state == ISSUE);
  assign bus.res_ready = (state == WAIT);
  assign bus.m_valid   = (state == DONE);

  assign bus.add_a   = (state == ISSUE) ? acc  : 16'h0000;
  assign bus.add_b   = (state == ISSUE) ? opnd : 16'h0000;
  assign bus.m_data  = (state == DONE)  ? acc  : 16'h0000;
  assign bus.m_count = (state == DONE)  ? cnt  : '0;
endmodule
